// File: rtl/tube_bus_pkg.sv
// tube_bus_pkg: shared widths, arbiter states and tube register offsets
package tube_bus_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    localparam logic [2:0] TUBE_WORD_OFS = 3'd0;
    localparam logic [2:0] TUBE2_OFS = 3'd4;
    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker, favours the port that did not win last
module rr_arb2 (
    input  logic [1:0] eligible_i,
    input  logic       rr_last_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);
    assign gnt_valid_o = |eligible_i;
    assign gnt_id_o = (&eligible_i) ? !rr_last_i : eligible_i[1];
endmodule

// File: rtl/tube_access_arbiter.sv
// tube_access_arbiter: shares the tube register port between CPU bridge and debug loader, rate-limiting writes
module tube_access_arbiter #(
    parameter int MIN_WRITE_GAP = 16,
    parameter int DATA_W = tube_bus_pkg::DATA_W,
    parameter int ADDR_W = tube_bus_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wd0,
    output logic              ack0,
    output logic [DATA_W-1:0] rd0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wd1,
    output logic              ack1,
    output logic [DATA_W-1:0] rd1,
    output logic              dev_WE,
    output logic [ADDR_W-1:0] dev_ADDR,
    output logic [DATA_W-1:0] dev_WD,
    input  logic [DATA_W-1:0] dev_RD,
    output logic              busy
);
    import tube_bus_pkg::*;

    localparam int GW = (MIN_WRITE_GAP > 0) ? $clog2(MIN_WRITE_GAP + 1) : 1;

    state_e            state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              gnt_id_q, gnt_id_d;
    logic              cmd_we_q, cmd_we_d;
    logic              dev_we_q, dev_we_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wd_q, cmd_wd_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic [1:0]        eligible;
    logic              gnt_valid, gnt_id;

    // a write is only eligible once the previous write's gap has fully elapsed
    assign eligible = {req1 && (!we1 || gap_q == '0), req0 && (!we0 || gap_q == '0)};

    rr_arb2 u_rr (
        .eligible_i (eligible),
        .rr_last_i  (rr_last_q),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id)
    );

    // state register
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state_q <= IDLE;
        else state_q <= state_d;

    // next state: IDLE waits for a grant, ISSUE and ACK last one cycle each
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = gnt_valid ? ISSUE : IDLE;
            ISSUE:   state_d = ACK;
            default: state_d = IDLE;
        endcase
    end

    // command capture, device strobe, read capture, gap counter and ack generation
    always_comb begin
        rr_last_d  = rr_last_q;
        gnt_id_d   = gnt_id_q;
        cmd_we_d   = cmd_we_q;
        cmd_addr_d = cmd_addr_q;
        cmd_wd_d   = cmd_wd_q;
        rd0_d      = rd0_q;
        rd1_d      = rd1_q;
        gap_d      = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        dev_we_d   = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        if (state_q == IDLE && gnt_valid) begin
            gnt_id_d   = gnt_id;
            cmd_we_d   = gnt_id ? we1 : we0;
            cmd_addr_d = gnt_id ? addr1 : addr0;
            cmd_wd_d   = gnt_id ? wd1 : wd0;
            dev_we_d   = cmd_we_d;
        end
        if (state_q == ISSUE) begin
            ack0_d = !gnt_id_q;
            ack1_d = gnt_id_q;
            if (cmd_we_q) gap_d = GW'(MIN_WRITE_GAP);
            else if (gnt_id_q) rd1_d = dev_RD;
            else rd0_d = dev_RD;
        end
        if (state_q == ACK) rr_last_d = gnt_id_q;
    end

    // datapath registers; reset aborts any in-flight device write at once
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            rr_last_q  <= 1'b1;
            gnt_id_q   <= 1'b0;
            cmd_we_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_wd_q   <= '0;
            rd0_q      <= '0;
            rd1_q      <= '0;
            gap_q      <= '0;
            dev_we_q   <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            rr_last_q  <= rr_last_d;
            gnt_id_q   <= gnt_id_d;
            cmd_we_q   <= cmd_we_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_wd_q   <= cmd_wd_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
            gap_q      <= gap_d;
            dev_we_q   <= dev_we_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
        end

    assign dev_WE   = dev_we_q;
    assign dev_ADDR = cmd_addr_q;
    assign dev_WD   = cmd_wd_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rd0      = rd0_q;
    assign rd1      = rd1_q;
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_tube_access_arbiter.sv
// tb_tube_access_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_tube_access_arbiter;
    localparam int GAP = 16;

    logic        CLK, RST_N;
    logic        req0, we0, req1, we1, ack0, ack1, dev_WE, busy;
    logic [2:0]  addr0, addr1, dev_ADDR;
    logic [31:0] wd0, wd1, rd0, rd1, dev_WD, dev_RD;
    logic        z_req0, z_we0, z_req1, z_we1, z_ack0, z_ack1, z_dev_WE, z_busy;
    logic [2:0]  z_addr0, z_addr1, z_dev_ADDR;
    logic [31:0] z_wd0, z_wd1, z_rd0, z_rd1, z_dev_WD, z_dev_RD;
    logic [31:0] mem [8];
    int vecs = 0;
    int errs = 0;

    tube_access_arbiter #(.MIN_WRITE_GAP(GAP), .DATA_W(32), .ADDR_W(3)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0(req0), .we0(we0), .addr0(addr0), .wd0(wd0), .ack0(ack0), .rd0(rd0),
        .req1(req1), .we1(we1), .addr1(addr1), .wd1(wd1), .ack1(ack1), .rd1(rd1),
        .dev_WE(dev_WE), .dev_ADDR(dev_ADDR), .dev_WD(dev_WD), .dev_RD(dev_RD), .busy(busy)
    );

    tube_access_arbiter #(.MIN_WRITE_GAP(0), .DATA_W(32), .ADDR_W(3)) dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .req0(z_req0), .we0(z_we0), .addr0(z_addr0), .wd0(z_wd0), .ack0(z_ack0), .rd0(z_rd0),
        .req1(z_req1), .we1(z_we1), .addr1(z_addr1), .wd1(z_wd1), .ack1(z_ack1), .rd1(z_rd1),
        .dev_WE(z_dev_WE), .dev_ADDR(z_dev_ADDR), .dev_WD(z_dev_WD), .dev_RD(z_dev_RD), .busy(z_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // device model: register file reloaded with 0xA1+i while in reset
    always @(posedge CLK) begin
        if (!RST_N) for (int i = 0; i < 8; i++) mem[i] <= 32'hA1 + i;
        else if (dev_WE) mem[dev_ADDR] <= dev_WD;
    end
    assign dev_RD = mem[dev_ADDR];
    assign z_dev_RD = {29'b0, z_dev_ADDR};

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        req0 = 0; we0 = 0; addr0 = 0; wd0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wd1 = 0;
        z_req0 = 0; z_we0 = 0; z_addr0 = 0; z_wd0 = 0;
        z_req1 = 0; z_we1 = 0; z_addr1 = 0; z_wd1 = 0;
    endtask

    task automatic do_reset;
        RST_N = 0;
        clear_inputs;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1;
    endtask

    task automatic test_reset;
        RST_N = 0;
        clear_inputs;
        tick;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vecs++; if (dev_WE !== 1'b0) begin errs++; $display("FAIL reset_dev_we got=%b exp=0", dev_WE); end
        vecs++; if ({ack0, ack1} !== 2'b00) begin errs++; $display("FAIL reset_acks got=%b exp=00", {ack0, ack1}); end
        vecs++; if (rd0 !== 32'h0 || rd1 !== 32'h0) begin errs++; $display("FAIL reset_rd got=%h/%h exp=0/0", rd0, rd1); end
        vecs++; if (dev_ADDR !== 3'd0 || dev_WD !== 32'h0) begin errs++; $display("FAIL reset_dev_bus got=%h/%h exp=0/0", dev_ADDR, dev_WD); end
        vecs++; if (z_busy !== 1'b0) begin errs++; $display("FAIL reset_z_busy got=%b exp=0", z_busy); end
        tick;
        RST_N = 1;
    endtask

    task automatic test_read;
        do_reset;
        req0 = 1; we0 = 0; addr0 = 3'd4;
        tick;
        vecs++; if (dev_WE !== 1'b0) begin errs++; $display("FAIL read_dev_we got=%b exp=0", dev_WE); end
        vecs++; if (dev_ADDR !== 3'd4) begin errs++; $display("FAIL read_dev_addr got=%h exp=4", dev_ADDR); end
        vecs++; if (ack0 !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL read_issue_ack_busy got=%b%b exp=01", ack0, busy); end
        tick;
        vecs++; if (ack0 !== 1'b1) begin errs++; $display("FAIL read_ack0 got=%b exp=1", ack0); end
        vecs++; if (rd0 !== 32'h000000A5) begin errs++; $display("FAIL read_rd0 got=%h exp=000000a5", rd0); end
        vecs++; if (ack1 !== 1'b0) begin errs++; $display("FAIL read_ack1 got=%b exp=0", ack1); end
        req0 = 0;
        tick;
        vecs++; if ({ack0, ack1, busy} !== 3'b000) begin errs++; $display("FAIL read_idle got=%b exp=000", {ack0, ack1, busy}); end
    endtask

    task automatic test_write_pair;
        int c;
        do_reset;
        req0 = 1; we0 = 1; addr0 = 3'd0; wd0 = 32'h12345678;
        req1 = 1; we1 = 1; addr1 = 3'd4; wd1 = 32'h9ABCDEF0;
        tick;
        vecs++; if (dev_WE !== 1'b1 || dev_WD !== 32'h12345678) begin errs++; $display("FAIL wp_first got=%b/%h exp=1/12345678", dev_WE, dev_WD); end
        tick;
        vecs++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin errs++; $display("FAIL wp_ack0 got=%b%b exp=10", ack0, ack1); end
        req0 = 0;
        c = 2;
        while (dev_WE !== 1'b1 && c < 40) begin
            tick;
            c++;
        end
        vecs++; if (c - 1 !== GAP + 2) begin errs++; $display("FAIL wp_gap got=%0d exp=%0d", c - 1, GAP + 2); end
        vecs++; if (dev_WD !== 32'h9ABCDEF0 || dev_ADDR !== 3'd4) begin errs++; $display("FAIL wp_second got=%h/%h exp=9abcdef0/4", dev_WD, dev_ADDR); end
        tick;
        vecs++; if (ack1 !== 1'b1) begin errs++; $display("FAIL wp_ack1 got=%b exp=1", ack1); end
        req1 = 0;
        tick;
    endtask

    task automatic test_read_during_gap;
        do_reset;
        req0 = 1; we0 = 1; addr0 = 3'd1; wd0 = 32'hCAFE0001;
        req1 = 1; we1 = 0; addr1 = 3'd2;
        tick;
        vecs++; if (dev_WE !== 1'b1) begin errs++; $display("FAIL rg_write got=%b exp=1", dev_WE); end
        tick;
        wd0 = 32'hCAFE0002;
        tick;
        tick;
        vecs++; if (dev_WE !== 1'b0 || dev_ADDR !== 3'd2) begin errs++; $display("FAIL rg_read_issue got=%b/%h exp=0/2", dev_WE, dev_ADDR); end
        tick;
        vecs++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin errs++; $display("FAIL rg_ack1 got=%b%b exp=10", ack1, ack0); end
        vecs++; if (rd1 !== 32'h000000A3) begin errs++; $display("FAIL rg_rd1 got=%h exp=000000a3", rd1); end
        req0 = 0; req1 = 0;
        tick;
    endtask

    task automatic test_back_to_back;
        int c, n;
        logic id;
        do_reset;
        req0 = 1; we0 = 0; addr0 = 3'd1;
        req1 = 1; we1 = 0; addr1 = 3'd6;
        c = 0; n = 0;
        while (n < 8 && c < 40) begin
            tick;
            c++;
            if (ack0 || ack1) begin
                id = ack1;
                vecs++; if (id !== n[0]) begin errs++; $display("FAIL b2b_order[%0d] got=%b exp=%b", n, id, n[0]); end
                vecs++; if (c !== 2 + 3 * n) begin errs++; $display("FAIL b2b_time[%0d] got=%0d exp=%0d", n, c, 2 + 3 * n); end
                vecs++; if ((id ? rd1 : rd0) !== (id ? 32'hA7 : 32'hA2)) begin errs++; $display("FAIL b2b_rd[%0d] got=%h", n, id ? rd1 : rd0); end
                n++;
            end
        end
        vecs++; if (n !== 8) begin errs++; $display("FAIL b2b_count got=%0d exp=8", n); end
        req0 = 0; req1 = 0;
        tick;
    endtask

    task automatic test_reset_midwrite;
        do_reset;
        req1 = 1; we1 = 1; addr1 = 3'd3; wd1 = 32'h55AA55AA;
        tick;
        vecs++; if (dev_WE !== 1'b1) begin errs++; $display("FAIL rm_issue got=%b exp=1", dev_WE); end
        #2 RST_N = 0;
        #1;
        vecs++; if (dev_WE !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rm_async got=%b%b exp=00", dev_WE, busy); end
        @(posedge CLK);
        #1;
        vecs++; if (ack1 !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rm_noack got=%b%b exp=00", ack1, busy); end
        req0 = 1; we0 = 0; addr0 = 3'd0;
        req1 = 1; we1 = 0; addr1 = 3'd5;
        RST_N = 1;
        tick;
        tick;
        vecs++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin errs++; $display("FAIL rm_first_grant got=%b%b exp=10", ack0, ack1); end
        vecs++; if (rd0 !== 32'h000000A1) begin errs++; $display("FAIL rm_rd0 got=%h exp=000000a1", rd0); end
        req0 = 0; req1 = 0;
        tick;
        tick;
    endtask

    task automatic test_nogap;
        int n;
        logic exp_we, exp_ack;
        do_reset;
        z_req1 = 1; z_we1 = 1; z_addr1 = 3'd7; z_wd1 = 32'h10000000;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick;
            exp_we = (i % 3 == 1);
            exp_ack = (i % 3 == 2);
            vecs++; if (z_dev_WE !== exp_we) begin errs++; $display("FAIL ng_we[%0d] got=%b exp=%b", i, z_dev_WE, exp_we); end
            vecs++; if (z_ack1 !== exp_ack || z_ack0 !== 1'b0) begin errs++; $display("FAIL ng_ack[%0d] got=%b%b exp=0%b", i, z_ack0, z_ack1, exp_ack); end
            if (exp_we) begin
                vecs++; if (z_dev_WD !== 32'h10000000 + n) begin errs++; $display("FAIL ng_wd[%0d] got=%h exp=%h", i, z_dev_WD, 32'h10000000 + n); end
            end
            if (z_ack1) begin
                n++;
                if (n == 4) z_req1 = 0;
                else z_wd1 = 32'h10000000 + n;
            end
        end
        vecs++; if (n !== 4) begin errs++; $display("FAIL ng_count got=%0d exp=4", n); end
    endtask

    task automatic test_random;
        int nf, last_w, t_iss;
        bit rr, t_id, t_we, e0, e1, pend0, pend1, aprev0, aprev1;
        logic [2:0] t_addr;
        logic [31:0] t_wd, t_val, rexp0, rexp1;
        do_reset;
        nf = 0; last_w = -1000; t_iss = -10; rr = 1;
        t_id = 0; t_we = 0; t_addr = 0; t_wd = 0; t_val = 0;
        rexp0 = 0; rexp1 = 0; pend0 = 0; pend1 = 0; aprev0 = 0; aprev1 = 0;
        for (int n = 0; n < 800; n++) begin
            if (n > 0) tick;
            vecs++; if (dev_WE !== ((n == t_iss) && t_we)) begin errs++; $display("FAIL rnd_we@%0d got=%b", n, dev_WE); end
            vecs++; if (ack0 !== ((n == t_iss + 1) && !t_id)) begin errs++; $display("FAIL rnd_ack0@%0d got=%b", n, ack0); end
            vecs++; if (ack1 !== ((n == t_iss + 1) && t_id)) begin errs++; $display("FAIL rnd_ack1@%0d got=%b", n, ack1); end
            vecs++; if (busy !== (n == t_iss || n == t_iss + 1)) begin errs++; $display("FAIL rnd_busy@%0d got=%b", n, busy); end
            if (n == t_iss) begin
                vecs++; if (dev_ADDR !== t_addr || dev_WD !== t_wd) begin errs++; $display("FAIL rnd_bus@%0d got=%h/%h exp=%h/%h", n, dev_ADDR, dev_WD, t_addr, t_wd); end
                t_val = mem[t_addr];
            end
            if (n == t_iss + 1 && !t_we) begin
                if (t_id) rexp1 = t_val;
                else rexp0 = t_val;
            end
            vecs++; if (rd0 !== rexp0 || rd1 !== rexp1) begin errs++; $display("FAIL rnd_rd@%0d got=%h/%h exp=%h/%h", n, rd0, rd1, rexp0, rexp1); end
            if (aprev0) pend0 = 0;
            if (aprev1) pend1 = 0;
            if (!pend0 && $urandom_range(2) == 0) begin
                pend0 = 1; we0 = 1'($urandom_range(1)); addr0 = 3'($urandom_range(7)); wd0 = $urandom;
            end
            if (!pend1 && $urandom_range(2) == 0) begin
                pend1 = 1; we1 = 1'($urandom_range(1)); addr1 = 3'($urandom_range(7)); wd1 = $urandom;
            end
            req0 = pend0; req1 = pend1;
            aprev0 = ack0; aprev1 = ack1;
            if (n >= nf) begin
                e0 = req0 && (!we0 || n >= last_w + GAP + 1);
                e1 = req1 && (!we1 || n >= last_w + GAP + 1);
                if (e0 || e1) begin
                    t_id = (e0 && e1) ? !rr : e1;
                    rr = t_id;
                    t_we = t_id ? we1 : we0;
                    t_addr = t_id ? addr1 : addr0;
                    t_wd = t_id ? wd1 : wd0;
                    t_iss = n + 1;
                    nf = n + 3;
                    if (t_we) last_w = n + 1;
                end
            end
        end
        req0 = 0; req1 = 0;
        tick;
    endtask

    initial begin
        RST_N = 0;
        clear_inputs;
        test_reset;
        test_read;
        test_write_pair;
        test_read_during_gap;
        test_back_to_back;
        test_reset_midwrite;
        test_nogap;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/tube_access_arbiter.md
Name: tube_access_arbiter

Overview:
Shares the seven-segment tube peripheral's single register port between two requesters: port 0 is the CPU bridge and port 1 is the debug/UART loader. It issues one device transaction at a time with round-robin fairness. Every write to the tube restarts its digit scan, so writes are rate-limited by a minimum-gap counter to prevent visible flicker. Reads are never rate-limited. The block sits between the bridge/debug masters and the tube device's WE/WD/innerADDR/RD port.

Parameters:
- MIN_WRITE_GAP, 16: minimum cycles from one issued write to the next issued write. 0 disables the limit.
- DATA_W, 32: data width of the device port and requester ports.
- ADDR_W, 3: width of the device inner address (offset 0-3 word, offset >=4 tube2).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset. Single clock domain; reset is asynchronous and active-low.
- req0  in  1  port-0 request. Held high until ack0.
- we0  in  1  port-0 write enable. Stable while req0 is high.
- addr0  in  ADDR_W  port-0 inner address. Stable while req0 is high.
- wd0  in  DATA_W  port-0 write data. Stable while req0 is high.
- ack0  out  1  port-0 one-cycle completion pulse.
- rd0  out  DATA_W  port-0 read data. Valid from the ack0 cycle.
- req1, we1, addr1, wd1, ack1, rd1: same as port 0, for port 1.
- dev_WE  out  1  device write enable.
- dev_ADDR  out  ADDR_W  device inner address.
- dev_WD  out  DATA_W  device write data.
- dev_RD  in  DATA_W  device read data (combinational from dev_ADDR).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state=IDLE; rr_last=1, so port 0 wins the first tie; gap_cnt=0; cmd registers=0; ack0, ack1, dev_WE, busy=0; rd0, rd1=0; dev_ADDR, dev_WD=0.
- FSM has three states, one transaction every 3 cycles minimum:
  - IDLE -> ISSUE when any requester is eligible.
  - ISSUE -> ACK unconditionally.
  - ACK -> IDLE unconditionally.
- Eligibility: eligible_i = req_i && (!we_i || gap_cnt==0).
- Arbitration, IDLE only:
  - One eligible: grant it.
  - Both eligible: grant the port != rr_last.
  - On grant: capture we/addr/wd into cmd regs and record gnt_id.
- ISSUE:
  - dev_ADDR = cmd_addr, dev_WD = cmd_wd, dev_WE = cmd_we. These are driven from registers and held exactly this one cycle.
  - Outside ISSUE, dev_WE=0 and dev_ADDR/dev_WD hold their last values.
  - If cmd_we: load gap_cnt=MIN_WRITE_GAP at the end of ISSUE.
  - If !cmd_we: capture dev_RD into rd[gnt_id] at the end of ISSUE.
- ACK:
  - ack[gnt_id]=1 for exactly one cycle; rr_last <= gnt_id.
  - rd of the port is unchanged on writes and holds until that port's next read.
- Latency: a request seen eligible in IDLE cycle k gives device access in k+1 and ack in k+2.
- Requester rule: drop req (or present a new command) on the edge ack is seen. A req still high in the following IDLE starts a new transaction.
- gap_cnt: decrements by 1 every cycle while nonzero, in every state. It saturates at 0. Width is clog2(MIN_WRITE_GAP+1), minimum 1.
- A blocked write does not block the other port's reads. A port's own pending write does not lose its round-robin turn: rr_last only updates on an ack.
- Address passes through unmodified. The arbiter does not decode offsets.
- Reset asserted mid-transaction: immediate return to reset values, no ack, device write aborted (dev_WE drops asynchronously).
- Requests are ignored in ISSUE and ACK. No queueing; no combinational path from req to ack.

Decomposition:
- Package tube_bus_pkg holds:
  - ADDR_W and DATA_W;
  - the state enum (IDLE, ISSUE, ACK);
  - tube offset constants TUBE_WORD_OFS=3'd0 and TUBE2_OFS=3'd4.
- One sub-module is natural: rr_arb2. It is a 2-way combinational round-robin picker taking eligible[1:0] and rr_last and returning gnt_valid and gnt_id. Everything else stays in tube_access_arbiter.

Test Plan:
1. Port 0 read, addr 4, dev_RD=0x000000A5 -> dev_WE stays 0, dev_ADDR=4 in k+1, ack0 at k+2, rd0=0x000000A5, ack1 never asserts.
2. Both ports write together, MIN_WRITE_GAP=16, wd0=0x12345678, wd1=0x9ABCDEF0 -> port 0 issues first with dev_WD=0x12345678. Port 1's dev_WE occurs no earlier than 17 cycles after port 0's ISSUE cycle and carries 0x9ABCDEF0.
3. Port 0 writes, then port 1 reads in the next IDLE -> the read issues and ack1 arrives within 3 cycles while gap_cnt is still nonzero.
4. Both ports hold back-to-back reads for 8 transactions -> grant order 0,1,0,1,0,1,0,1, one ack every 3 cycles.
5. RST_N pulsed low during ISSUE of a write -> dev_WE falls with no clock edge, no ack, busy=0. The first grant after release goes to port 0.
6. MIN_WRITE_GAP=0, port 1 issues 4 consecutive writes -> dev_WE pulses every 3 cycles and ack1 follows each pulse by 1 cycle.
